// File: rtl/plot_arbiter_if.sv
// Pixel request bus between the three drawing engines and the arbiter,
// together with the arbiter's registered output towards the VGA adapter.
// Requester i occupies x[8i+7:8i], y[7i+6:7i] and colour[3i+2:3i].
interface plot_arbiter_if;
    logic [2:0]  req_valid;
    logic [23:0] req_x;
    logic [20:0] req_y;
    logic [8:0]  req_colour;
    logic [2:0]  req_ready;

    logic [7:0]  vga_x;
    logic [6:0]  vga_y;
    logic [2:0]  vga_colour;
    logic        vga_plot;
    logic [7:0]  clip_count;
    logic        busy;

    // Drawing-engine side: offers pixels, observes grants and adapter output.
    modport master (
        output req_valid, req_x, req_y, req_colour,
        input  req_ready, vga_x, vga_y, vga_colour, vga_plot, clip_count, busy
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_x, req_y, req_colour,
        output req_ready, vga_x, vga_y, vga_colour, vga_plot, clip_count, busy
    );
endinterface

// File: rtl/plot_arbiter.sv
// Round-robin arbiter that merges pixel streams from the fillscreen, circle
// and reuleaux engines into a single registered plot port for the VGA
// adapter. Pixels outside the visible area are accepted and counted but are
// never plotted.
module plot_arbiter #(
    parameter int unsigned XMAX = 159,
    parameter int unsigned YMAX = 119
) (
    input logic          clk,
    input logic          rst_n,
    plot_arbiter_if.slave bus
);

    localparam logic [7:0] X_LIM = 8'(XMAX);
    localparam logic [6:0] Y_LIM = 7'(YMAX);

    // Requester 2 is the reset owner of the pointer so that requester 0 is
    // first in line after reset.
    localparam logic [1:0] LAST_RESET = 2'd2;

    logic [1:0] last_q;
    logic [1:0] grant_idx;
    logic       grant_hit;
    logic       xfer;
    logic [7:0] sel_x;
    logic [6:0] sel_y;
    logic [2:0] sel_colour;
    logic       on_screen;

    // Wrap-around successor of a requester index (0 -> 1 -> 2 -> 0).
    function automatic logic [1:0] next_idx(input logic [1:0] idx);
        return (idx == 2'd2) ? 2'd0 : idx + 2'd1;
    endfunction

    // Round-robin search starting just after the last granted requester.
    always_comb begin
        logic [1:0] cand;
        // NOTE: every variable written here gets a default first, so no path
        // leaves it unassigned and no latch is inferred.
        grant_idx = 2'd0;
        grant_hit = 1'b0;
        cand      = next_idx(last_q);
        for (int k = 0; k < 3; k++) begin
            if (!grant_hit && bus.req_valid[cand]) begin
                grant_hit = 1'b1;
                grant_idx = cand;
            end
            cand = next_idx(cand);
        end
    end

    // One-hot grant, suppressed while reset is held.
    always_comb begin
        bus.req_ready = 3'b000;
        if (rst_n && grant_hit) begin
            bus.req_ready = 3'b001 << grant_idx;
        end
    end

    assign xfer = rst_n && grant_hit;

    // Select the granted requester's pixel and decide whether it is visible.
    always_comb begin
        sel_x      = bus.req_x[7:0];
        sel_y      = bus.req_y[6:0];
        sel_colour = bus.req_colour[2:0];
        case (grant_idx)
            2'd1: begin
                sel_x      = bus.req_x[15:8];
                sel_y      = bus.req_y[13:7];
                sel_colour = bus.req_colour[5:3];
            end
            2'd2: begin
                sel_x      = bus.req_x[23:16];
                sel_y      = bus.req_y[20:14];
                sel_colour = bus.req_colour[8:6];
            end
            default: ;
        endcase
        on_screen = (sel_x <= X_LIM) && (sel_y <= Y_LIM);
    end

    // Last-grant pointer advances only when a pixel actually moves.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state is updated with non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (!rst_n) begin
            last_q <= LAST_RESET;
        end else if (xfer) begin
            last_q <= grant_idx;
        end
    end

    // Registered plot port: visible pixels are forwarded with a one-cycle
    // strobe; clipped pixels and idle cycles leave the coordinates untouched.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: reset clears the in-flight pixel so nothing half-drawn is
        // replayed to the adapter after a mid-stream reset.
        if (!rst_n) begin
            bus.vga_x      <= 8'd0;
            bus.vga_y      <= 7'd0;
            bus.vga_colour <= 3'd0;
            bus.vga_plot   <= 1'b0;
        end else if (xfer && on_screen) begin
            bus.vga_x      <= sel_x;
            bus.vga_y      <= sel_y;
            bus.vga_colour <= sel_colour;
            bus.vga_plot   <= 1'b1;
        end else begin
            bus.vga_plot   <= 1'b0;
        end
    end

    // Saturating counter of pixels dropped for being off-screen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.clip_count <= 8'd0;
        end else if (xfer && !on_screen && bus.clip_count != 8'hFF) begin
            bus.clip_count <= bus.clip_count + 8'd1;
        end
    end

    // Activity flag: some requester was asking during the previous cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.busy <= 1'b0;
        end else begin
            bus.busy <= |bus.req_valid;
        end
    end

endmodule
